cpu_load_ctrl: RTL and testbench

CPU_LOAD_CTRL -- requirements
Module: cpu_load_ctrl

---
 rtl/cpu_load_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_load_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_load_ctrl.sv
// Program loader and run/step controller for a small core: assembles loader bytes
// into instruction words, writes them to instruction memory, and gates the core enable.
module cpu_load_ctrl #(
   parameter int NB_INSTRUCTION  = 32,
   parameter int NB_BYTE         = 8,
   parameter int IMEM_ADDR_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic [NB_BYTE-1:0]         i_rx_data,
   input  logic                       i_rx_valid,
   input  logic [IMEM_ADDR_WIDTH:0]   i_word_count,
   input  logic                       i_cmd_load,
   input  logic                       i_cmd_run,
   input  logic                       i_cmd_step,
   input  logic                       i_cmd_halt,
   input  logic                       i_cpu_halt,
   output logic [NB_INSTRUCTION-1:0]  o_imem_data,
   output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
   output logic                       o_imem_wen,
   output logic [1:0]                 o_mem_wsize,
   output logic                       o_cpu_en,
   output logic [1:0]                 o_state,
   output logic                       o_load_done
);

   localparam int NBYTES = NB_INSTRUCTION / NB_BYTE;
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CW     = IMEM_ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH     = CW'(2 ** IMEM_ADDR_WIDTH);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      STEP = 2'd3
   } state_t;

   state_t                     state_reg, state_next;
   logic [CW-1:0]              count_reg, word_idx_reg, count_sel;
   logic [BW-1:0]              byte_cnt_reg;
   logic [NB_INSTRUCTION-1:0]  asm_reg, asm_next, imem_data_reg;
   logic [IMEM_ADDR_WIDTH-1:0] imem_waddr_reg;
   logic                       imem_wen_reg, load_done_reg, cpu_en_reg;
   logic                       start_load, accept_byte, word_done, last_word;

   assign count_sel = (i_word_count > DEPTH) ? DEPTH : i_word_count;

   // Little-endian placement: byte k of a word lands in slot k.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_asm
      assign asm_next[gi*NB_BYTE +: NB_BYTE] =
         (byte_cnt_reg == BW'(gi)) ? i_rx_data : asm_reg[gi*NB_BYTE +: NB_BYTE];
   end

   always_comb begin
      state_next  = state_reg;
      start_load  = 1'b0;
      accept_byte = 1'b0;
      word_done   = 1'b0;
      last_word   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_cmd_halt) begin
               state_next = IDLE;
            end else if (i_cmd_load) begin
               start_load = 1'b1;
               if (count_sel != '0) state_next = LOAD;
            end else if (i_cmd_run) begin
               state_next = RUN;
            end else if (i_cmd_step) begin
               state_next = STEP;
            end
         end
         LOAD: begin
            if (i_cmd_halt) begin
               state_next = IDLE;
            end else if (i_rx_valid) begin
               accept_byte = 1'b1;
               if (byte_cnt_reg == LAST_BYTE) begin
                  word_done = 1'b1;
                  if (word_idx_reg + CW'(1) == count_reg) begin
                     last_word  = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
         end
         RUN:     if (i_cpu_halt || i_cmd_halt) state_next = IDLE;
         STEP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg      <= IDLE;
         count_reg      <= '0;
         word_idx_reg   <= '0;
         byte_cnt_reg   <= '0;
         asm_reg        <= '0;
         imem_data_reg  <= '0;
         imem_waddr_reg <= '0;
         imem_wen_reg   <= 1'b0;
         load_done_reg  <= 1'b0;
         cpu_en_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         imem_wen_reg  <= word_done;
         // An empty load completes immediately without touching memory.
         load_done_reg <= last_word || (start_load && count_sel == '0);
         cpu_en_reg    <= (state_next == RUN) || (state_next == STEP);
         if (start_load) begin
            count_reg    <= count_sel;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
         end else if (accept_byte) begin
            if (word_done) begin
               imem_data_reg  <= asm_next;
               imem_waddr_reg <= word_idx_reg[IMEM_ADDR_WIDTH-1:0];
               word_idx_reg   <= word_idx_reg + CW'(1);
               byte_cnt_reg   <= '0;
               asm_reg        <= '0;
            end else begin
               byte_cnt_reg <= byte_cnt_reg + BW'(1);
               asm_reg      <= asm_next;
            end
         end
      end
   end

   assign o_imem_data  = imem_data_reg;
   assign o_imem_waddr = imem_waddr_reg;
   assign o_imem_wen   = imem_wen_reg;
   assign o_mem_wsize  = imem_wen_reg ? 2'b10 : 2'b00;
   assign o_cpu_en     = cpu_en_reg;
   assign o_state      = state_reg;
   assign o_load_done  = load_done_reg;

endmodule

// File: tb/tb_cpu_load_ctrl.sv
// Bench for cpu_load_ctrl: expected memory writes are queued as bytes are driven
// and matched against each write strobe; control behaviour is checked inline.
`timescale 1ns/1ps
module tb_cpu_load_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [5:0]  word_count;
   logic        cmd_load, cmd_run, cmd_step, cmd_halt, cpu_halt;
   logic [31:0] imem_data;
   logic [4:0]  imem_waddr;
   logic        imem_wen;
   logic [1:0]  mem_wsize;
   logic        cpu_en;
   logic [1:0]  state;
   logic        load_done;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        done;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;

   cpu_load_ctrl #(.NB_INSTRUCTION(32), .NB_BYTE(8), .IMEM_ADDR_WIDTH(5)) dut (
      .clk          (clk),
      .i_rst        (rst),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .i_word_count (word_count),
      .i_cmd_load   (cmd_load),
      .i_cmd_run    (cmd_run),
      .i_cmd_step   (cmd_step),
      .i_cmd_halt   (cmd_halt),
      .i_cpu_halt   (cpu_halt),
      .o_imem_data  (imem_data),
      .o_imem_waddr (imem_waddr),
      .o_imem_wen   (imem_wen),
      .o_mem_wsize  (mem_wsize),
      .o_cpu_en     (cpu_en),
      .o_state      (state),
      .o_load_done  (load_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write-side scoreboard: every strobe must match the oldest queued expectation.
   always @(posedge clk) begin
      #1;
      if (load_done) done_cnt++;
      if (imem_wen) begin
         wr_cnt++;
         if (sb.size() == 0) begin
            check_eq("unexpected_wen", 64'(imem_waddr), 64'hdead);
         end else begin
            e = sb.pop_front();
            $display("write addr=%0d data=%08h done=%0b", imem_waddr, imem_data, load_done);
            check_eq("wr_addr", 64'(imem_waddr), 64'(e.addr));
            check_eq("wr_data", 64'(imem_data), 64'(e.data));
            check_eq("wr_done", 64'(load_done), 64'(e.done));
            check_eq("wr_size", 64'(mem_wsize), 64'd2);
            if (e.done) check_eq("state_at_done", 64'(state), 64'd0);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_cmd(input bit ld, input bit run, input bit step, input bit halt,
                            input logic [5:0] wc);
      @(negedge clk);
      rx_valid = 1'b0;
      cmd_load = ld; cmd_run = run; cmd_step = step; cmd_halt = halt;
      word_count = wc;
      @(negedge clk);
      cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w, input int addr, input bit done,
                            input bit expect_wr);
      exp_t x;
      if (expect_wr) begin
         x.addr = 5'(addr);
         x.data = w;
         x.done = done;
         sb.push_back(x);
      end
      for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
   endtask

   task automatic idle_rx;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   int wr0, dn0, cnt;
   logic [31:0] w;

   initial begin
      rst = 1'b1; rx_data = '0; rx_valid = 1'b0; word_count = '0;
      cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cpu_halt = 1'b0;
      wait_cycles(3);
      check_eq("rst_state", 64'(state), 64'd0);
      check_eq("rst_wen", 64'(imem_wen), 64'd0);
      check_eq("rst_done", 64'(load_done), 64'd0);
      check_eq("rst_cpu_en", 64'(cpu_en), 64'd0);
      check_eq("rst_wsize", 64'(mem_wsize), 64'd0);
      check_eq("rst_data", 64'(imem_data), 64'd0);
      check_eq("rst_waddr", 64'(imem_waddr), 64'd0);
      rst = 1'b0;
      wait_cycles(2);

      // Two-word load, little-endian assembly.
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_cmd(1, 0, 0, 0, 6'd2);
      check_eq("load_state", 64'(state), 64'd1);
      check_eq("load_cpu_en", 64'(cpu_en), 64'd0);
      send_word(32'h44332211, 0, 0, 1);
      send_word(32'h88776655, 1, 1, 1);
      idle_rx();
      wait_cycles(3);
      check_eq("n2_writes", 64'(wr_cnt - wr0), 64'd2);
      check_eq("n2_done", 64'(done_cnt - dn0), 64'd1);
      check_eq("n2_state", 64'(state), 64'd0);
      check_eq("hold_data", 64'(imem_data), 64'h88776655);
      check_eq("hold_addr", 64'(imem_waddr), 64'd1);

      // Count above depth is clamped; trailing bytes fall into IDLE and are dropped.
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_cmd(1, 0, 0, 0, 6'd40);
      for (int i = 0; i < 32; i++) begin
         w = $urandom;
         send_word(w, i, i == 31, 1);
      end
      for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
      idle_rx();
      wait_cycles(3);
      check_eq("clamp_writes", 64'(wr_cnt - wr0), 64'd32);
      check_eq("clamp_done", 64'(done_cnt - dn0), 64'd1);
      check_eq("clamp_last_addr", 64'(imem_waddr), 64'd31);

      // Halt mid-load discards the partial word.
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_cmd(1, 0, 0, 0, 6'd3);
      send_word(32'hCAFEF00D, 0, 0, 1);
      send_byte(8'h01);
      send_byte(8'h02);
      pulse_cmd(0, 0, 0, 1, 6'd0);
      check_eq("halt_state", 64'(state), 64'd0);
      wait_cycles(3);
      check_eq("halt_writes", 64'(wr_cnt - wr0), 64'd1);
      check_eq("halt_done", 64'(done_cnt - dn0), 64'd0);
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_cmd(1, 0, 0, 0, 6'd1);
      send_word(32'h0BADBEEF, 0, 1, 1);
      idle_rx();
      wait_cycles(3);
      check_eq("reload_writes", 64'(wr_cnt - wr0), 64'd1);
      check_eq("reload_done", 64'(done_cnt - dn0), 64'd1);

      // Zero-word load: done one cycle after the command, no writes, stays IDLE.
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_cmd(1, 0, 0, 0, 6'd0);
      check_eq("n0_done_pulse", 64'(load_done), 64'd1);
      check_eq("n0_state", 64'(state), 64'd0);
      wait_cycles(1);
      check_eq("n0_done_clear", 64'(load_done), 64'd0);
      wait_cycles(2);
      check_eq("n0_writes", 64'(wr_cnt - wr0), 64'd0);
      check_eq("n0_done_cnt", 64'(done_cnt - dn0), 64'd1);

      // Free run until the core reports halt after ten enabled cycles.
      pulse_cmd(0, 1, 0, 0, 6'd0);
      check_eq("run_state", 64'(state), 64'd2);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (cpu_en) cnt++;
         cpu_halt = (cnt == 10) && cpu_en;
         @(negedge clk);
      end
      cpu_halt = 1'b0;
      check_eq("run_en_cycles", 64'(cnt), 64'd10);
      check_eq("run_end_state", 64'(state), 64'd0);

      // Single step, with and without the core halt flag raised.
      for (int h = 0; h < 2; h++) begin
         cpu_halt = h[0];
         pulse_cmd(0, 0, 1, 0, 6'd0);
         check_eq("step_state", 64'(state), 64'd3);
         cnt = 0;
         for (int i = 0; i < 6; i++) begin
            if (cpu_en) cnt++;
            @(negedge clk);
         end
         check_eq("step_en_cycles", 64'(cnt), 64'd1);
         check_eq("step_end_state", 64'(state), 64'd0);
      end
      cpu_halt = 1'b0;

      // Load wins over a simultaneous run; run during LOAD is ignored.
      wr0 = wr_cnt;
      pulse_cmd(1, 1, 0, 0, 6'd1);
      check_eq("prio_state", 64'(state), 64'd1);
      check_eq("prio_cpu_en", 64'(cpu_en), 64'd0);
      pulse_cmd(0, 1, 0, 0, 6'd0);
      check_eq("run_in_load_state", 64'(state), 64'd1);
      check_eq("run_in_load_en", 64'(cpu_en), 64'd0);
      send_word(32'h13579BDF, 0, 1, 1);
      idle_rx();
      wait_cycles(3);
      check_eq("prio_writes", 64'(wr_cnt - wr0), 64'd1);

      // Asynchronous reset in the middle of a word.
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_cmd(1, 0, 0, 0, 6'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_state", 64'(state), 64'd0);
      check_eq("arst_data", 64'(imem_data), 64'd0);
      check_eq("arst_waddr", 64'(imem_waddr), 64'd0);
      check_eq("arst_wen", 64'(imem_wen), 64'd0);
      check_eq("arst_cpu_en", 64'(cpu_en), 64'd0);
      wait_cycles(2);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
      idle_rx();
      wait_cycles(3);
      check_eq("arst_writes", 64'(wr_cnt - wr0), 64'd0);
      check_eq("arst_done", 64'(done_cnt - dn0), 64'd0);
      check_eq("arst_idle", 64'(state), 64'd0);
      check_eq("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
